// File: rtl/irq_controller.sv
// External-interrupt source for cop0: latches rising edges of the peripheral lines,
// picks the lowest-index enabled event, and runs a req/ack/eret handshake with one interrupt in service at a time.
module irq_controller #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_src,
    input  logic             i_mask_we,
    input  logic [N_SRC-1:0] i_mask_data,
    input  logic             i_ack,
    input  logic             i_eret,
    output logic             o_irq,
    output logic [ID_W-1:0]  o_irq_id,
    output logic [N_SRC-1:0] o_pending,
    output logic [N_SRC-1:0] o_mask,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [N_SRC-1:0] src_q_r;
    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] mask_r;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  id_next_s;
    logic             irq_r;
    logic             busy_r;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] cand_s;
    logic [N_SRC-1:0] clr_s;
    logic [ID_W-1:0]  win_id_s;

    function automatic logic [N_SRC-1:0] onehot_f(input logic [ID_W-1:0] idx);
        logic [N_SRC-1:0] v;
        for (int k = 0; k < N_SRC; k++) begin
            v[k] = (ID_W'(k) == idx);
        end
        return v;
    endfunction

    assign rise_s = i_src & ~src_q_r;
    assign cand_s = pending_r & mask_r;

    // Lowest-index candidate wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win_id_s = {ID_W{1'b0}};
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (cand_s[k]) begin
                win_id_s = ID_W'(k);
            end else begin
                win_id_s = win_id_s;
            end
        end
    end

    // Handshake next-state, id latch and pending-clear decode.
    always_comb begin
        state_next_s = state_r;
        id_next_s    = id_r;
        clr_s        = {N_SRC{1'b0}};
        case (state_r)
            IDLE: begin
                if (cand_s != {N_SRC{1'b0}}) begin
                    state_next_s = REQ;
                    id_next_s    = win_id_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                // The request stays up with a frozen id until cop0 acknowledges it.
                if (i_ack) begin
                    state_next_s = SERVICE;
                    clr_s        = onehot_f(id_r);
                end else begin
                    state_next_s = REQ;
                end
            end
            SERVICE: begin
                if (i_eret) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVICE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, registers and registered outputs; a new edge beats a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            src_q_r   <= {N_SRC{1'b0}};
            pending_r <= {N_SRC{1'b0}};
            mask_r    <= {N_SRC{1'b0}};
            id_r      <= {ID_W{1'b0}};
            irq_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            src_q_r   <= i_src;
            pending_r <= (pending_r & ~clr_s) | rise_s;
            mask_r    <= i_mask_we ? i_mask_data : mask_r;
            id_r      <= id_next_s;
            irq_r     <= (state_next_s == REQ);
            busy_r    <= (state_next_s == SERVICE);
        end
    end

    assign o_irq     = irq_r;
    assign o_irq_id  = id_r;
    assign o_pending = pending_r;
    assign o_mask    = mask_r;
    assign o_busy    = busy_r;

endmodule
